// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_pkg
//  Description : Shared definitions for the I/O event handler: helpers that
//                turn time spans into clock-cycle counts, and the encoding
//                of the per-button hold classifier states.
//  Contents    : us_to_cycles(freq_hz, len_us) -> cycles
//                ms_to_cycles(freq_hz, len_ms) -> cycles
//                ST_RELEASED / ST_HELD / ST_LONG (2-bit state codes)
//  Revision    : 1.0 - initial release
// ============================================================================
package io_pkg;

   // Cycles per microsecond interval. freq_hz is a whole multiple of 1 MHz.
   function automatic int unsigned us_to_cycles(input int unsigned freq_hz,
                                                input int unsigned len_us);
      return len_us * (freq_hz / 1_000_000);
   endfunction

   function automatic int unsigned ms_to_cycles(input int unsigned freq_hz,
                                                input int unsigned len_ms);
      return len_ms * (freq_hz / 1_000);
   endfunction

   // Hold classifier state encoding
   localparam logic [1:0] ST_RELEASED = 2'd0;
   localparam logic [1:0] ST_HELD     = 2'd1;
   localparam logic [1:0] ST_LONG     = 2'd2;

endpackage
`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
// ============================================================================
//  Module      : button_channel
//  Description : One button path: 2-FF synchroniser, polarity normalisation,
//                debounce and press / short-release / long-hold classifier.
//  Ports       : sys_clk, sys_rst_n  - clock, async active-low reset
//                btn_raw             - raw asynchronous button input
//                btn_level           - debounced level, 1 = pressed
//                btn_press           - 1-cycle pulse on accepted press
//                btn_short           - 1-cycle pulse on release (no long)
//                btn_long            - 1-cycle pulse when hold hits LONG_COUNT
//  Revision    : 1.0 - initial release
// ============================================================================
module button_channel
   import io_pkg::*;
#(
   parameter bit          ACTIVE_LOW     = 1'b1,
   parameter int unsigned DEBOUNCE_COUNT = 12_000,
   parameter int unsigned LONG_COUNT     = 12_000_000
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press,
   output logic btn_short,
   output logic btn_long
);

   localparam int unsigned     c_DB_W      = $clog2(DEBOUNCE_COUNT + 1);
   localparam int unsigned     c_HOLD_W    = $clog2(LONG_COUNT + 1);
   localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_COUNT - 1);
   localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(LONG_COUNT - 1);
   localparam logic [c_HOLD_W-1:0] c_HOLD_MAX  = c_HOLD_W'(LONG_COUNT);
   localparam logic            c_IDLE      = ACTIVE_LOW;

   logic [1:0]          r_sync;
   logic                w_synced;
   logic                r_level;
   logic [c_DB_W-1:0]   r_db_cnt;
   logic [1:0]          r_state;
   logic [1:0]          w_state_nxt;
   logic [c_HOLD_W-1:0] r_hold_cnt;
   logic                w_long_hit;

   // Synchroniser resets to the idle raw level so no phantom edge appears
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) r_sync <= {2{c_IDLE}};
      else            r_sync <= {r_sync[0], btn_raw};
   end

   // XOR with the idle level yields active-high "pressed"
   assign w_synced = r_sync[1] ^ c_IDLE;

   // Debounce: count consecutive cycles of disagreement, accept at the last
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_level  <= 1'b0;
         r_db_cnt <= '0;
      end else if (w_synced == r_level) begin
         r_db_cnt <= '0;
      end else if (r_db_cnt == c_DB_LAST) begin
         r_level  <= ~r_level;
         r_db_cnt <= '0;
      end else begin
         r_db_cnt <= r_db_cnt + 1'b1;
      end
   end

   assign btn_level  = r_level;
   assign w_long_hit = (r_hold_cnt == c_HOLD_LAST);

   // Classifier: state register and hold counter
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state    <= ST_RELEASED;
         r_hold_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_RELEASED)
            r_hold_cnt <= '0;
         else if (r_state == ST_HELD && r_hold_cnt != c_HOLD_MAX)
            r_hold_cnt <= r_hold_cnt + 1'b1;
      end
   end

   // Classifier: next state. Reaching the long threshold wins over a
   // simultaneous release, so a hold of exactly LONG_COUNT is a long press.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RELEASED: if (r_level)      w_state_nxt = ST_HELD;
         ST_HELD: begin
            if (w_long_hit)             w_state_nxt = ST_LONG;
            else if (!r_level)          w_state_nxt = ST_RELEASED;
         end
         ST_LONG:     if (!r_level)     w_state_nxt = ST_RELEASED;
         default:                       w_state_nxt = ST_RELEASED;
      endcase
   end

   // Classifier: event pulses, decoded from the current state and level so
   // that press coincides with the level rise and short with the level fall.
   always_comb begin
      btn_press = (r_state == ST_RELEASED) &&  r_level;
      btn_long  = (r_state == ST_HELD)     &&  w_long_hit;
      btn_short = (r_state == ST_HELD)     && !r_level && !w_long_hit;
   end

endmodule
`default_nettype wire

// File: rtl/io_event_handler.sv
`default_nettype none
// ============================================================================
//  Module      : io_event_handler
//  Description : Button and LED front end for the MITM logic. Debounces and
//                classifies NUM_BUTTONS buttons, steps a one-hot mode with
//                button 0 (short = forward, long = backward) and stretches
//                the comm-activity LED.
//  Ports       : sys_clk, sys_rst_n      - clock, async active-low reset
//                btn_in[NUM_BUTTONS]     - raw buttons
//                comm_active             - raw bus-activity flag
//                btn_level/press/short/long[NUM_BUTTONS] - button events
//                mode_select, mode_leds  - one-hot mode
//                mode_changed            - pulse when the mode updates
//                comm_active_led         - stretched activity indicator
//  Revision    : 1.0 - initial release
// ============================================================================
module io_event_handler
   import io_pkg::*;
#(
   parameter int unsigned NUM_BUTTONS        = 3,
   parameter int unsigned NUM_MITM_MODES     = 4,
   parameter bit          BUTTONS_ACTIVE_LOW = 1'b1,
   parameter int unsigned SYS_FREQ_HZ        = 12_000_000,
   parameter int unsigned DEBOUNCE_LEN_US    = 1_000,
   parameter int unsigned LONG_PRESS_MS      = 1_000,
   parameter int unsigned LED_HOLD_MS        = 50
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst_n,
   input  logic [NUM_BUTTONS-1:0]    btn_in,
   input  logic                      comm_active,
   output logic [NUM_BUTTONS-1:0]    btn_level,
   output logic [NUM_BUTTONS-1:0]    btn_press,
   output logic [NUM_BUTTONS-1:0]    btn_short,
   output logic [NUM_BUTTONS-1:0]    btn_long,
   output logic [NUM_MITM_MODES-1:0] mode_select,
   output logic                      mode_changed,
   output logic [NUM_MITM_MODES-1:0] mode_leds,
   output logic                      comm_active_led
);

   localparam int unsigned c_DEBOUNCE_COUNT = us_to_cycles(SYS_FREQ_HZ, DEBOUNCE_LEN_US);
   localparam int unsigned c_LONG_COUNT     = ms_to_cycles(SYS_FREQ_HZ, LONG_PRESS_MS);
   localparam int unsigned c_LED_COUNT      = ms_to_cycles(SYS_FREQ_HZ, LED_HOLD_MS);
   localparam int unsigned c_LED_W          = $clog2(c_LED_COUNT + 1);
   localparam logic [c_LED_W-1:0]        c_LED_RELOAD = c_LED_W'(c_LED_COUNT);
   localparam logic [NUM_MITM_MODES-1:0] c_MODE_RESET = {{(NUM_MITM_MODES-1){1'b0}}, 1'b1};

   logic [NUM_MITM_MODES-1:0] r_mode;
   logic                      r_mode_changed;
   logic [1:0]                r_comm_sync;
   logic                      w_comm_synced;
   logic [c_LED_W-1:0]        r_led_cnt;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
         button_channel #(
            .ACTIVE_LOW     (BUTTONS_ACTIVE_LOW),
            .DEBOUNCE_COUNT (c_DEBOUNCE_COUNT),
            .LONG_COUNT     (c_LONG_COUNT)
         ) u_channel (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .btn_raw   (btn_in[gi]),
            .btn_level (btn_level[gi]),
            .btn_press (btn_press[gi]),
            .btn_short (btn_short[gi]),
            .btn_long  (btn_long[gi])
         );
      end
   endgenerate

   // Mode rotation; a single button cannot give short and long together
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_mode         <= c_MODE_RESET;
         r_mode_changed <= 1'b0;
      end else begin
         r_mode_changed <= 1'b0;
         if (btn_short[0]) begin
            r_mode         <= {r_mode[NUM_MITM_MODES-2:0], r_mode[NUM_MITM_MODES-1]};
            r_mode_changed <= 1'b1;
         end else if (btn_long[0]) begin
            r_mode         <= {r_mode[0], r_mode[NUM_MITM_MODES-1:1]};
            r_mode_changed <= 1'b1;
         end
      end
   end

   assign mode_select  = r_mode;
   assign mode_leds    = r_mode;
   assign mode_changed = r_mode_changed;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) r_comm_sync <= 2'b00;
      else            r_comm_sync <= {r_comm_sync[0], comm_active};
   end

   assign w_comm_synced = r_comm_sync[1];

   // Activity keeps the hold counter topped up; it drains once activity stops
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)             r_led_cnt <= '0;
      else if (w_comm_synced)     r_led_cnt <= c_LED_RELOAD;
      else if (r_led_cnt != '0)   r_led_cnt <= r_led_cnt - 1'b1;
   end

   assign comm_active_led = w_comm_synced | (r_led_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_io_event_handler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_event_handler
//  Description : Self-checking bench for io_event_handler. A vector table of
//                button presses with expected event counts and mode, then
//                hand-written timing sequences (debounce latency, exact long
//                hold, reset mid-press, concurrency, LED stretch/reload).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_event_handler;

   localparam int NB = 3;
   localparam int NM = 4;

   logic          sys_clk = 1'b0;
   logic          sys_rst_n = 1'b0;
   logic [NB-1:0] btn_in = '1;
   logic          comm_active = 1'b0;
   logic [NB-1:0] btn_level, btn_press, btn_short, btn_long;
   logic [NM-1:0] mode_select, mode_leds;
   logic          mode_changed, comm_active_led;

   io_event_handler #(
      .NUM_BUTTONS        (NB),
      .NUM_MITM_MODES     (NM),
      .BUTTONS_ACTIVE_LOW (1'b1),
      .SYS_FREQ_HZ        (1_000_000),
      .DEBOUNCE_LEN_US    (4),
      .LONG_PRESS_MS      (1),
      .LED_HOLD_MS        (1)
   ) dut (
      .sys_clk         (sys_clk),
      .sys_rst_n       (sys_rst_n),
      .btn_in          (btn_in),
      .comm_active     (comm_active),
      .btn_level       (btn_level),
      .btn_press       (btn_press),
      .btn_short       (btn_short),
      .btn_long        (btn_long),
      .mode_select     (mode_select),
      .mode_changed    (mode_changed),
      .mode_leds       (mode_leds),
      .comm_active_led (comm_active_led)
   );

   always #5 sys_clk = ~sys_clk;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   int press_cnt[NB], short_cnt[NB], long_cnt[NB];
   int press_cyc[NB], short_cyc[NB], long_cyc[NB], rise_cyc[NB], fall_cyc[NB];
   int chg_cnt, chg_cyc, led_cnt, led_first, led_last;
   logic [NB-1:0] lvl_prev = '0;

   typedef struct {
      logic [NB-1:0] mask;
      int            hold;
      logic [NB-1:0] press;
      logic [NB-1:0] sh;
      logic [NB-1:0] lg;
      logic [NM-1:0] mode;
      int            chg;
   } vec_t;

   localparam int NV = 8;
   vec_t vec[NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic clear_stats();
      for (int b = 0; b < NB; b++) begin
         press_cnt[b] = 0; short_cnt[b] = 0; long_cnt[b] = 0;
         press_cyc[b] = -1; short_cyc[b] = -1; long_cyc[b] = -1;
         rise_cyc[b]  = -1; fall_cyc[b]  = -1;
      end
      chg_cnt = 0; chg_cyc = -1;
      led_cnt = 0; led_first = -1; led_last = -1;
   endtask

   // Advance one clock and record what the DUT shows in the new cycle
   task automatic step();
      @(posedge sys_clk);
      #1;
      cyc++;
      for (int b = 0; b < NB; b++) begin
         if (btn_press[b]) begin press_cnt[b]++; press_cyc[b] = cyc; end
         if (btn_short[b]) begin short_cnt[b]++; short_cyc[b] = cyc; end
         if (btn_long[b])  begin long_cnt[b]++;  long_cyc[b]  = cyc; end
         if ( btn_level[b] && !lvl_prev[b]) rise_cyc[b] = cyc;
         if (!btn_level[b] &&  lvl_prev[b]) fall_cyc[b] = cyc;
      end
      lvl_prev = btn_level;
      if (mode_changed) begin chg_cnt++; chg_cyc = cyc; end
      if (comm_active_led) begin
         led_cnt++;
         if (led_first < 0) led_first = cyc;
         led_last = cyc;
      end
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   initial begin
      int c0;
      int c1;

      //              mask    hold  press   short   long    mode     chg
      vec[0] = '{3'b010,    3, 3'b000, 3'b000, 3'b000, 4'b0001, 0};  // glitch
      vec[1] = '{3'b010,   20, 3'b010, 3'b010, 3'b000, 4'b0001, 0};
      vec[2] = '{3'b001,  200, 3'b001, 3'b001, 3'b000, 4'b0010, 1};
      vec[3] = '{3'b001,  200, 3'b001, 3'b001, 3'b000, 4'b0100, 1};
      vec[4] = '{3'b001,  200, 3'b001, 3'b001, 3'b000, 4'b1000, 1};
      vec[5] = '{3'b001,  200, 3'b001, 3'b001, 3'b000, 4'b0001, 1};  // wrap
      vec[6] = '{3'b110,   50, 3'b110, 3'b110, 3'b000, 4'b0001, 0};
      vec[7] = '{3'b001, 1500, 3'b001, 3'b000, 3'b001, 4'b1000, 1};  // long

      clear_stats();
      steps(3);
      check("reset btn_level",       32'(btn_level),       0);
      check("reset btn_press",       32'(btn_press),       0);
      check("reset btn_short",       32'(btn_short),       0);
      check("reset btn_long",        32'(btn_long),        0);
      check("reset mode_select",     32'(mode_select),     1);
      check("reset mode_leds",       32'(mode_leds),       1);
      check("reset mode_changed",    32'(mode_changed),    0);
      check("reset comm_active_led", 32'(comm_active_led), 0);
      sys_rst_n = 1'b1;
      steps(5);

      // ---------------- vector table ----------------
      for (int v = 0; v < NV; v++) begin
         clear_stats();
         btn_in = ~vec[v].mask;
         steps(vec[v].hold);
         btn_in = '1;
         steps(30);
         for (int b = 0; b < NB; b++) begin
            check($sformatf("v%0d press[%0d] count", v, b), press_cnt[b], 32'(vec[v].press[b]));
            check($sformatf("v%0d short[%0d] count", v, b), short_cnt[b], 32'(vec[v].sh[b]));
            check($sformatf("v%0d long[%0d] count",  v, b), long_cnt[b],  32'(vec[v].lg[b]));
         end
         check($sformatf("v%0d mode_select", v), 32'(mode_select), 32'(vec[v].mode));
         check($sformatf("v%0d mode_leds", v),   32'(mode_leds),   32'(vec[v].mode));
         check($sformatf("v%0d mode_changed count", v), chg_cnt, vec[v].chg);
      end

      // ---------------- debounce latency and short timing (button 1) -------
      clear_stats();
      c0 = cyc;
      btn_in = ~3'b010;
      steps(20);
      btn_in = '1;
      steps(30);
      check("latency press[1]",  press_cyc[1] - c0, 6);
      check("latency level[1]",  rise_cyc[1] - c0,  6);
      check("fall level[1]",     fall_cyc[1] - c0,  26);
      check("short[1] at fall",  short_cyc[1],      fall_cyc[1]);

      // ---------------- exact LONG_COUNT hold (mode 1000 -> 0100) ----------
      clear_stats();
      c0 = cyc;
      btn_in = ~3'b001;
      steps(1000);
      btn_in = '1;
      steps(30);
      check("exact press[0] latency",  press_cyc[0] - c0, 6);
      check("exact long after press",  long_cyc[0] - press_cyc[0], 1000);
      check("exact fall level[0]",     fall_cyc[0] - c0, 1006);
      check("exact long count",        long_cnt[0], 1);
      check("exact no short",          short_cnt[0], 0);
      check("exact mode_changed lag",  chg_cyc - long_cyc[0], 1);
      check("exact mode_select",       32'(mode_select), 32'(4'b0100));

      // ---------------- reset mid-hold at mode 0100 ----------------
      clear_stats();
      btn_in = ~3'b001;
      steps(506);
      #2;
      sys_rst_n = 1'b0;
      #1;
      check("midrst btn_level",       32'(btn_level),       0);
      check("midrst btn_press",       32'(btn_press),       0);
      check("midrst btn_short",       32'(btn_short),       0);
      check("midrst btn_long",        32'(btn_long),        0);
      check("midrst mode_select",     32'(mode_select),     1);
      check("midrst mode_changed",    32'(mode_changed),    0);
      check("midrst comm_active_led", 32'(comm_active_led), 0);
      steps(3);
      sys_rst_n = 1'b1;
      clear_stats();
      c1 = cyc;
      steps(20);
      check("postrst press latency", press_cyc[0] - c1, 6);
      check("postrst press count",   press_cnt[0], 1);
      btn_in = '1;
      steps(30);
      check("postrst short mode",    32'(mode_select), 32'(4'b0010));

      // ---------------- short press timing (mode 0010 -> 0100) ----------
      clear_stats();
      btn_in = ~3'b001;
      steps(200);
      btn_in = '1;
      steps(30);
      check("short[0] at fall",       short_cyc[0], fall_cyc[0]);
      check("short mode_changed lag", chg_cyc - short_cyc[0], 1);
      check("short mode_select",      32'(mode_select), 32'(4'b0100));
      check("short no long",          long_cnt[0], 0);

      // ---------------- concurrency ----------------
      clear_stats();
      c0 = cyc;
      btn_in = ~3'b110;
      steps(30);
      btn_in = '1;
      steps(30);
      check("conc press[1] latency", press_cyc[1] - c0, 6);
      check("conc press[2] latency", press_cyc[2] - c0, 6);
      check("conc mode unchanged",   32'(mode_select), 32'(4'b0100));
      check("conc no mode change",   chg_cnt, 0);

      // ---------------- LED stretch ----------------
      clear_stats();
      c0 = cyc;
      comm_active = 1'b1;
      step();
      comm_active = 1'b0;
      steps(1100);
      check("led rise",       led_first - c0, 2);
      check("led high count", led_cnt, 1001);
      check("led last",       led_last - c0, 1002);

      // ---------------- LED reload mid-hold ----------------
      clear_stats();
      c0 = cyc;
      comm_active = 1'b1;
      step();
      comm_active = 1'b0;
      steps(499);
      comm_active = 1'b1;
      step();
      comm_active = 1'b0;
      steps(1600);
      check("reload led rise",       led_first - c0, 2);
      check("reload led high count", led_cnt, 1501);
      check("reload led last",       led_last - c0, 1502);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/io_event_handler.md
# io_event_handler

Parametrised successor to the single-mode-button I/O handler; sits between the board buttons and LEDs and the MITM logic module. It synchronises and debounces `NUM_BUTTONS` raw button inputs and classifies each press as press, short-release or long-hold event. Button 0 steps the one-hot MITM mode forward on a short press and backward on a long press. A pulse stretcher keeps the comm-activity LED visible for short bursts.

## Interface
- `NUM_BUTTONS`, 3: raw button count, ≥2; bit 0 is the mode button.
- `NUM_MITM_MODES`, 4: one-hot mode width, ≥2.
- `BUTTONS_ACTIVE_LOW`, 1: raw button polarity.
- `SYS_FREQ_HZ`, 12_000_000: clock frequency, a multiple of 1_000_000.
- `DEBOUNCE_LEN_US`, 1_000: stable time before a level change is accepted.
- `LONG_PRESS_MS`, 1_000: hold time that qualifies as a long press.
- `LED_HOLD_MS`, 50: minimum comm LED on-time.

Ports:
- `sys_clk` in 1: single system clock; all logic is on its rising edge.
- `sys_rst_n` in 1: reset, asynchronous assert, active-low.
- `btn_in` in NUM_BUTTONS: raw buttons, asynchronous.
- `comm_active` in 1: bus-activity flag, asynchronous.
- `btn_level` out NUM_BUTTONS: debounced level, active-high (1 = pressed).
- `btn_press` out NUM_BUTTONS: 1-cycle pulse on an accepted press.
- `btn_short` out NUM_BUTTONS: 1-cycle pulse on release when no long event fired.
- `btn_long` out NUM_BUTTONS: 1-cycle pulse when the hold reaches `LONG_COUNT`.
- `mode_select` out NUM_MITM_MODES: one-hot current mode.
- `mode_changed` out 1: 1-cycle pulse, asserted in the same cycle `mode_select` updates.
- `mode_leds` out NUM_MITM_MODES: equals `mode_select`.
- `comm_active_led` out 1: stretched activity indicator.

## Operation
- **Derived counts:**
  - `DEBOUNCE_COUNT = DEBOUNCE_LEN_US*(SYS_FREQ_HZ/1_000_000)`, must be ≥1.
  - `LONG_COUNT = LONG_PRESS_MS*(SYS_FREQ_HZ/1000)`.
  - `LED_COUNT = LED_HOLD_MS*(SYS_FREQ_HZ/1000)`.
  - Each counter is `$clog2(count+1)` bits wide and unsigned.
- **Synchroniser:** 2 flip-flops per input, reset to the inactive raw level. Polarity is normalised to active-high after the synchroniser.
- **Debounce (per button):**
  - The counter clears whenever the synced value equals `btn_level`, and increments otherwise.
  - When the counter reaches `DEBOUNCE_COUNT-1` while values still differ, `btn_level` toggles and the counter clears.
  - A glitch shorter than `DEBOUNCE_COUNT` cycles produces no output.
- **Hold classifier (per button):** states RELEASED, HELD, LONG.
  - RELEASED→HELD on a `btn_level` rise; `btn_press`=1 and the hold counter clears.
  - HELD: the hold counter increments. On reaching `LONG_COUNT` it moves to LONG and asserts `btn_long`=1 once.
  - HELD→RELEASED on a level fall: `btn_short`=1.
  - LONG→RELEASED on a level fall: no pulse.
  - The hold counter saturates; one long event fires per press.
- **Mode register:**
  - On `btn_short[0]`, rotate left (bit MSB wraps to bit 0).
  - On `btn_long[0]`, rotate right (bit 0 wraps to MSB).
  - The two are mutually exclusive by construction.
- **LED stretcher:**
  - While synced `comm_active`=1, the counter reloads `LED_COUNT`.
  - Otherwise it decrements to 0 and saturates there.
  - `comm_active_led = sync_comm_active | (counter != 0)`.
- **Reset values:**
  - `btn_level`, `btn_press`, `btn_short`, `btn_long`, `mode_changed`, `comm_active_led` all 0.
  - `mode_select` = 1; all counters 0; classifiers in RELEASED.

## Timing
- A raw edge sampled at cycle 0 gives `btn_level` change and `btn_press` at cycle `2+DEBOUNCE_COUNT`.
- `btn_long` fires `LONG_COUNT` cycles after `btn_press`.
- `btn_short` fires in the cycle `btn_level` falls.
- `mode_select` and `mode_changed` update one cycle after the `btn_short[0]`/`btn_long[0]` pulse.
- `comm_active_led` rises 2 cycles after `comm_active`. It falls `LED_COUNT` cycles after the synced signal drops.
- **Simultaneous presses on different buttons:** handled independently, with no priority.
- **Reset mid-press:** all state is discarded. A button still held after reset release is re-debounced and reported as a fresh press.
- **Long hold exactly `LONG_COUNT` cycles then release:** `btn_long` fires and `btn_short` does not.

## Structure
- Shared package `io_pkg`: the count-derivation functions (`us_to_cycles`, `ms_to_cycles`) and the classifier state encoding (RELEASED, HELD, LONG).
- Sub-module `button_channel`: synchroniser, debounce and classifier for one button, instantiated `NUM_BUTTONS` times via generate.
- The top level holds the mode register, the LED stretcher and the `comm_active` synchroniser.

## Test plan
Bench parameters: `SYS_FREQ_HZ=1_000_000`, `DEBOUNCE_LEN_US=4`, `LONG_PRESS_MS=1`, `LED_HOLD_MS=1`. This gives DEBOUNCE_COUNT=4, LONG_COUNT=1000 and LED_COUNT=1000.

1. **Glitch rejection:** a 3-cycle low pulse on `btn_in[1]` → no `btn_level`/`btn_press` activity. A 20-cycle pulse → `btn_press[1]` at cycle 6 after the edge.
2. **Short press cycle:** press `btn_in[0]` for 200 cycles, four times → `mode_select` steps 0001→0010→0100→1000→0001. Four `mode_changed` pulses, no `btn_long`.
3. **Long press:** hold `btn_in[0]` for 1500 cycles from reset → `btn_long[0]` exactly 1000 cycles after `btn_press[0]`. `mode_select`=1000 and no `btn_short` on release.
4. **LED stretch:** a 1-cycle `comm_active` → `comm_active_led` high from cycle +2 for 1001 cycles. A second pulse mid-hold reloads the count.
5. **Reset mid-operation:** assert `sys_rst_n` low 500 cycles into a hold at mode 0100 → all outputs 0, `mode_select`=0001 asynchronously. After release with the button still down → new `btn_press` after 6 cycles.
6. **Concurrency:** press buttons 1 and 2 in the same cycle → coincident `btn_press[1]` and `btn_press[2]`, `mode_select` unchanged.
